// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core pipeline control.
// Holds the data-memory wait FSM encoding, the hard-wired zero register
// index and the default mult/div occupancy.
package mips_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  // $zero is never written, so a load targeting it can never create a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MD_LATENCY_DEFAULT = 32;

endpackage

// File: rtl/md_busy_timer.sv
// Occupancy timer for the multi-cycle mult/div unit.
// Ports: clk/reset (sync, active-high); load starts a LATENCY-cycle busy
// window; busy is high while the count is non-zero; done marks its last cycle.
module md_busy_timer #(
  parameter int LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic done
);

  localparam int W = $clog2(LATENCY + 1);

  logic [W-1:0] cnt;

  // The count keeps running through pipeline freezes: the functional unit
  // itself is not stalled by the memory wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign busy = (cnt != '0);
  // Count of 1 means the unit frees on the coming edge; a waiting mfhi/mflo
  // or second mult/div can issue in the following cycle.
  assign done = (cnt == W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer: per-cycle advance/hold/flush of PC, IF/ID,
// ID/EX and EX/MEM for load-use, taken-branch, mult/div and memory-wait.
// Ports: clk/reset (sync, active-high); ID/EX/MEM hazard inputs; register
// write/flush controls; md_busy/md_done; stall_cycles counts pc_write=0 cycles.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,  // must be >= 2
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic             id_md_use,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  mem_state_t state, state_next;
  logic       freeze;
  logic       load_use;
  logic       md_hazard;
  logic       md_accept;
  logic       tmr_busy;
  logic       tmr_done;

  // Memory wait FSM: the access that misses freezes its first cycle already,
  // and the cycle mem_ready arrives is still frozen so MEM can capture data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    freeze     = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        freeze = 1'b1;
        if (mem_ready) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  assign md_hazard = tmr_busy && (id_md_use || id_md_start);

  // A mult/div only starts when its instruction actually leaves ID this cycle.
  assign md_accept = id_md_start && !tmr_busy && !freeze &&
                     !ex_branch_taken && !load_use && !reset;

  md_busy_timer #(
    .LATENCY(MD_LATENCY)
  ) u_md_timer (
    .clk  (clk),
    .reset(reset),
    .load (md_accept),
    .busy (tmr_busy),
    .done (tmr_done)
  );

  // Priority: reset, freeze, taken branch, mult/div stall, load-use stall.
  // While frozen the branch is ignored; EX holds so it is seen again later.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (md_hazard || load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign md_busy = tmr_busy && !reset;
  assign md_done = tmr_done && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_write) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus a randomized run
// against a cycle-level reference model of the sequencing rules.
module tb_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rs, id_uses_rt, id_md_start, id_md_use;
  logic          ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write;
  logic          id_ex_flush, ex_mem_write, md_busy, md_done;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_md_use(id_md_use),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
    .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic pc_write, if_id_write, if_id_flush, id_ex_write;
    logic id_ex_flush, ex_mem_write, md_busy, md_done;
  } ctl_t;

  localparam logic [7:0] RST  = 8'b0011_1100;
  localparam logic [7:0] DEF  = 8'b1101_0100;
  localparam logic [7:0] STL  = 8'b0001_1100;  // stall bubble, md idle
  localparam logic [7:0] BRF  = 8'b1111_1100;  // branch flush
  localparam logic [7:0] FRZ  = 8'b0000_0000;

  ctl_t got;
  assign got = {pc_write, if_id_write, if_id_flush, id_ex_write,
                id_ex_flush, ex_mem_write, md_busy, md_done};

  int tests = 0;
  int fails = 0;

  // Reference model state: memory still outstanding, mult/div cycles left,
  // stall counter value.
  bit m_wait = 1'b0;
  int m_md = 0;
  int m_stalls = 0;

  function automatic ctl_t model_out();
    ctl_t e;
    bit frozen, lu;
    if (reset) begin
      e = ctl_t'(RST);
      return e;
    end
    e = ctl_t'(DEF);
    e.md_busy = (m_md > 0);
    e.md_done = (m_md == 1);
    frozen = m_wait || (mem_req && !mem_ready);
    lu = ex_memread && (ex_rt != 5'd0) &&
         ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    if (frozen) begin
      e.pc_write = 0; e.if_id_write = 0; e.id_ex_write = 0; e.ex_mem_write = 0;
    end else if (ex_branch_taken) begin
      e.if_id_flush = 1; e.id_ex_flush = 1;
    end else if ((m_md > 0 && (id_md_use || id_md_start)) || lu) begin
      e.pc_write = 0; e.if_id_write = 0; e.id_ex_flush = 1;
    end
    return e;
  endfunction

  // One clock: advance the model with the inputs present before the edge,
  // then return at the next falling edge ready for new stimulus.
  task automatic step();
    ctl_t e;
    bit frozen;
    e = model_out();
    frozen = m_wait || (mem_req && !mem_ready);
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_md = 0; m_stalls = 0;
    end else begin
      if (!e.pc_write) m_stalls = (m_stalls + 1) % (1 << CW);
      // A start issues only when its instruction moves on normally.
      if (id_md_start && e.pc_write && !e.id_ex_flush) m_md = LAT;
      else if (m_md > 0) m_md = m_md - 1;
      m_wait = frozen && !mem_ready;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_md_start = 0; id_md_use = 0; ex_memread = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (got !== RST) begin fails++; $display("FAIL reset_outputs: got %b expected %b", got, RST); end
    step();
    #1;
    tests++;
    if (stall_cycles !== 4'd0) begin fails++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    reset = 0;
    #1;
    tests++;
    if (got !== DEF) begin fails++; $display("FAIL post_reset_default: got %b expected %b", got, DEF); end
    step();
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    tests++;
    if (got !== STL) begin fails++; $display("FAIL load_use_stall: got %b expected %b", got, STL); end
    step();
    idle();
    #1;
    tests++;
    if (got !== DEF || stall_cycles !== 4'd1) begin
      fails++; $display("FAIL load_use_one_bubble: got %b/%0d expected %b/1", got, stall_cycles, DEF);
    end
    set_load_use();
    ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    tests++;
    if (got !== DEF) begin fails++; $display("FAIL load_use_zero_reg: got %b expected %b", got, DEF); end
    step();
    idle();
  endtask

  task automatic test_branch_vs_hazard();
    set_load_use();
    ex_branch_taken = 1;
    #1;
    tests++;
    if (got !== BRF) begin fails++; $display("FAIL branch_over_load_use: got %b expected %b", got, BRF); end
    step();
    idle();
    #1;
    tests++;
    if (stall_cycles !== 4'd1) begin fails++; $display("FAIL branch_no_stall_count: got %0d expected 1", stall_cycles); end
  endtask

  task automatic test_mem_wait();
    for (int c = 1; c <= 4; c++) begin
      mem_req = 1; mem_ready = (c == 4); ex_branch_taken = 1;
      #1;
      tests++;
      if (got !== FRZ) begin fails++; $display("FAIL mem_freeze_c%0d: got %b expected %b", c, got, FRZ); end
      step();
    end
    mem_req = 0; mem_ready = 0; ex_branch_taken = 1;
    #1;
    tests++;
    if (got !== BRF || stall_cycles !== 4'd5) begin
      fails++; $display("FAIL mem_release_branch: got %b/%0d expected %b/5", got, stall_cycles, BRF);
    end
    step();
    idle();
  endtask

  task automatic test_md();
    logic [7:0] exp;
    id_md_start = 1;
    #1;
    tests++;
    if (got !== DEF) begin fails++; $display("FAIL md_start_issue: got %b expected %b", got, DEF); end
    step();
    id_md_start = 0; id_md_use = 1;
    for (int k = 1; k <= 4; k++) begin
      exp = (k == 4) ? 8'b0001_1111 : 8'b0001_1110;
      #1;
      tests++;
      if (got !== exp) begin fails++; $display("FAIL md_use_wait_k%0d: got %b expected %b", k, got, exp); end
      step();
    end
    #1;
    tests++;
    if (got !== DEF) begin fails++; $display("FAIL md_use_proceeds: got %b expected %b", got, DEF); end
    step();
    idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    id_md_start = 1;
    step();
    for (int k = 1; k <= 5; k++) begin
      exp = (k == 5) ? DEF : ((k == 4) ? 8'b0001_1111 : 8'b0001_1110);
      #1;
      tests++;
      if (got !== exp) begin fails++; $display("FAIL b2b_second_k%0d: got %b expected %b", k, got, exp); end
      step();
    end
    id_md_start = 0;
    for (int k = 6; k <= 10; k++) begin
      exp = (k == 10) ? DEF : ((k == 9) ? 8'b1101_0111 : 8'b1101_0110);
      #1;
      tests++;
      if (got !== exp) begin fails++; $display("FAIL b2b_busy_k%0d: got %b expected %b", k, got, exp); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    id_md_start = 1;
    step();
    id_md_start = 0; mem_req = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++;
      if (got !== 8'b0000_0010) begin fails++; $display("FAIL mid_freeze_busy_k%0d: got %b expected 00000010", k, got); end
      step();
    end
    reset = 1;
    #1;
    tests++;
    if (got !== RST) begin fails++; $display("FAIL mid_reset_outputs: got %b expected %b", got, RST); end
    step();
    reset = 0;
    idle();
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (got !== DEF || stall_cycles !== 4'd0) begin
        fails++; $display("FAIL after_mid_reset_k%0d: got %b/%0d expected %b/0", k, got, stall_cycles, DEF);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    mem_req = 1;
    for (int c = 1; c <= 16; c++) begin
      mem_ready = (c == 16);
      step();
    end
    idle();
    #1;
    tests++;
    if (stall_cycles !== 4'd0 || got !== DEF) begin
      fails++; $display("FAIL stall_wrap: got %0d/%b expected 0/%b", stall_cycles, got, DEF);
    end
  endtask

  task automatic test_random();
    ctl_t e;
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 49) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_memread      = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      id_md_start     = ($urandom_range(0, 7) == 0);
      id_md_use       = ($urandom_range(0, 3) == 0);
      mem_req         = ($urandom_range(0, 3) == 0);
      mem_ready       = 1'($urandom_range(0, 1));
      #1;
      e = model_out();
      tests++;
      if (got !== e || stall_cycles !== CW'(m_stalls)) begin
        fails++;
        $display("FAIL random_n%0d: got %b/%0d expected %b/%0d", n, got, stall_cycles, e, m_stalls);
      end
      step();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_vs_hazard();
    test_mem_wait();
    test_md();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
